// File: rtl/ysyx_22040365_wbu.sv
// Write-back unit: one-entry result register, 32 x XLEN integer regfile, two read ports, retire counter.
// Optional macro YSYX_22040365_WB_BYPASS_EN forwards the pending result to the read ports.
module ysyx_22040365_wbu #(
    parameter int XLEN    = 64,
    parameter int NR_REGS = 32,
    parameter int AW      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wen_rd,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wb_stall,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            commit_valid,
    output logic [AW-1:0]   commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic [63:0]     retire_cnt
);

    logic            wb_vld;
    logic            wb_wen;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] regs [NR_REGS];

    logic fire_in;
    logic fire_out;

    // A full register that commits this cycle can take a new entry without a bubble.
    assign ex_ready = rst || !wb_vld || !wb_stall;
    assign fire_out = !rst && wb_vld && !wb_stall;
    assign fire_in  = ex_valid && ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld     <= 1'b0;
            wb_wen     <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else begin
            if (fire_in) begin
                wb_vld  <= 1'b1;
                wb_wen  <= wen_rd;
                wb_rd   <= rd_addr;
                wb_data <= ex_result;
            end else if (fire_out) begin
                wb_vld <= 1'b0;
            end
            if (fire_out) begin
                retire_cnt <= retire_cnt + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (fire_out && wb_wen && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign commit_valid = fire_out;
    assign commit_rd    = wb_wen ? wb_rd : '0;
    assign commit_data  = wb_data;

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!rst) begin
            if (rs1_addr != '0) begin
                rs1_data = regs[rs1_addr];
            end
            if (rs2_addr != '0) begin
                rs2_data = regs[rs2_addr];
            end
`ifdef YSYX_22040365_WB_BYPASS_EN
            // Forwarding ignores wb_stall so a held result is already visible to decode.
            if (wb_vld && wb_wen && (wb_rd == rs1_addr) && (rs1_addr != '0)) begin
                rs1_data = wb_data;
            end
            if (wb_vld && wb_wen && (wb_rd == rs2_addr) && (rs2_addr != '0)) begin
                rs2_data = wb_data;
            end
`endif
        end
    end

endmodule

// File: doc/ysyx_22040365_wbu.md
Name: ysyx_22040365_wbu

Overview:
- Write-back unit: the receiving end of the execute-stage result interface (ex_result, wen_rd, destination register).
- Holds one in-flight result in a pipeline register and commits it to a 32-entry x XLEN integer register file.
- Serves two combinational source-operand read ports to the decode/operand-fetch logic.
- Counts retired instructions.

Parameters:
- XLEN, 64, datapath and register width
- NR_REGS, 32, number of architectural integer registers; x0 reads as zero
- AW, 5, register address width (log2 NR_REGS)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- ex_valid  input  1  execute stage presents a result this cycle
- ex_ready  output  1  write-back can accept the presented result
- ex_result  input  XLEN  result value from execute
- wen_rd  input  1  result is to be written to rd
- rd_addr  input  AW  destination register index
- wb_stall  input  1  hold the pending entry, no commit this cycle
- rs1_addr  input  AW  read port 1 index
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_addr  input  AW  read port 2 index
- rs2_data  output  XLEN  read port 2 data (combinational)
- commit_valid  output  1  one-cycle pulse: entry retired this cycle
- commit_rd  output  AW  retired destination index (0 if no write)
- commit_data  output  XLEN  retired value
- retire_cnt  output  64  number of retired entries since reset

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Pipeline register: holds wb_vld, wb_wen, wb_rd, wb_data.
- Accept (fire_in) = ex_valid && ex_ready.
- Commit (fire_out) = wb_vld && !wb_stall.
- ex_ready = !wb_vld || !wb_stall. This is combinational; a full register that commits in the same cycle accepts a new entry (no bubble).
- On fire_in, the register loads {1, wen_rd, rd_addr, ex_result}.
- Else on fire_out, wb_vld clears to 0. Other fields hold.
- Latency: a result accepted at edge N commits at edge N+1 if wb_stall is low in that cycle. The regfile reflects it from edge N+1.
- Regfile write: on fire_out && wb_wen && wb_rd != 0, regs[wb_rd] <= wb_data.
- Writes to x0 are dropped. The entry still retires and retire_cnt still increments.
- commit_valid = fire_out, combinational from the registered state.
- commit_rd = wb_wen ? wb_rd : 0.
- commit_data = wb_data.
- retire_cnt increments by 1 on every fire_out and wraps from 2^64-1 to 0.
- Reads: rsN_data = 0 when rsN_addr == 0, otherwise regs[rsN_addr] (subject to the bypass feature).
- wb_stall held high: the entry stays pending indefinitely, ex_ready stays 0 while wb_vld = 1, and nothing is written.
- ex_valid with wb_vld = 0: always accepted, regardless of wb_stall.
- Reset mid-operation: the pending entry is discarded, never written, and not counted.
- Reset values: wb_vld=0, wb_wen=0, wb_rd=0, wb_data=0, all regs=0, retire_cnt=0.
- Outputs during reset: ex_ready=1, commit_valid=0, rs1_data=rs2_data=0.

Optional Feature:
- Macro: YSYX_22040365_WB_BYPASS_EN.
- Defined: rsN_data returns wb_data when wb_vld && wb_wen && wb_rd == rsN_addr && rsN_addr != 0. The value is forwarded whether or not wb_stall is high, so reads of a pending result see it before it commits.
- Undefined: reads return regfile contents only. A pending result is visible only from the edge it commits; the hazard unit must stall dependent reads.

Test Plan:
- Reset then idle -> ex_ready=1, commit_valid=0, retire_cnt=0, rs1_addr=5 gives rs1_data=0.
- Accept {wen_rd=1, rd=3, 0x1234} with wb_stall=0 -> next cycle commit_valid=1, commit_rd=3, commit_data=0x1234; following cycle rs1_addr=3 reads 0x1234, retire_cnt=1.
- Write rd=0 with 0xFFFF -> commits, retire_cnt increments, rs2_addr=0 reads 0.
- Back-to-back: ex_valid high for 4 cycles writing x1..x4 = 10..40, wb_stall=0 -> ex_ready stays 1, four consecutive commit pulses, retire_cnt=4, x1..x4 read 10..40.
- Hold wb_stall=1 for 3 cycles with an entry {rd=7, 0xAA} pending -> ex_ready=0, no commit, x7 unchanged; with BYPASS_EN defined rs1_addr=7 reads 0xAA, without it reads the old value. Release -> one commit pulse.
- Assert rst while entry {rd=9, 0x55} is pending -> next cycle wb_vld=0, x9=0, retire_cnt=0, no commit pulse.
